// File: rtl/word_swap_if.sv
// ----------------------------------------------------------------------------
// word_swap_if
//   Bundles the request/response signals between the game controller and the
//   word swap sequencer (word_swap_ctrl).
//
//   Optional feature macro: SWAP_UNDO_EN (adds undo_pls).
//
//   Signals (direction as seen from the sequencer, i.e. the slave modport):
//     clear_pls   in   empty buffer (new game / logout)
//     load_pls    in   load word_in/target_in, restart move count
//     len_sel     in   word length select: 0->4 .. 3->7 letters
//     word_in     in   scrambled word, slot i = [i*LETTER_W +: LETTER_W]
//     target_in   in   solution word, same packing
//     swap_req    in   one-cycle request to swap idx1/idx2
//     idx1, idx2  in   slot indices to exchange
//     undo_pls    in   (SWAP_UNDO_EN only) revert the last completed swap
//     word_out    out  live buffer contents
//     busy        out  swap/check in progress
//     done_pls    out  swap finished, is_correct updated
//     err_pls     out  request rejected (index out of range)
//     is_correct  out  buffer matches target over active length
//     swap_cnt    out  accepted swaps since load, saturates at 127
// ----------------------------------------------------------------------------
interface word_swap_if #(
    parameter int LETTER_W = 5,
    parameter int MAX_LEN  = 7,
    parameter int IDX_W    = 3
);
    logic                          clear_pls;
    logic                          load_pls;
    logic [1:0]                    len_sel;
    logic [MAX_LEN*LETTER_W-1:0]   word_in;
    logic [MAX_LEN*LETTER_W-1:0]   target_in;
    logic                          swap_req;
    logic [IDX_W-1:0]              idx1;
    logic [IDX_W-1:0]              idx2;
`ifdef SWAP_UNDO_EN
    logic                          undo_pls;
`endif
    logic [MAX_LEN*LETTER_W-1:0]   word_out;
    logic                          busy;
    logic                          done_pls;
    logic                          err_pls;
    logic                          is_correct;
    logic [6:0]                    swap_cnt;

    // Game controller side
    modport master (
`ifdef SWAP_UNDO_EN
        output undo_pls,
`endif
        output clear_pls, load_pls, len_sel, word_in, target_in,
        output swap_req, idx1, idx2,
        input  word_out, busy, done_pls, err_pls, is_correct, swap_cnt
    );

    // Sequencer side
    modport slave (
`ifdef SWAP_UNDO_EN
        input  undo_pls,
`endif
        input  clear_pls, load_pls, len_sel, word_in, target_in,
        input  swap_req, idx1, idx2,
        output word_out, busy, done_pls, err_pls, is_correct, swap_cnt
    );
endinterface

// File: rtl/word_swap_ctrl.sv
// ----------------------------------------------------------------------------
// word_swap_ctrl
//   Sequences letter swaps on the scrambled-word buffer during play. A swap
//   request latches both letters, writes them back one slot per cycle
//   (WR1, WR2), then compares the buffer with the target word (CHECK) and
//   reports is_correct plus a saturating move count.
//
//   Optional feature macro: SWAP_UNDO_EN
//     When defined, undo_pls re-swaps the most recently completed pair once,
//     decrementing the move count (floor 0).
//
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   asynchronous reset, active-high
//     bus   word_swap_if.slave  (see word_swap_if.sv for signal list)
//
//   Priority per edge: clear_pls > load_pls > swap_req (> undo_pls).
// ----------------------------------------------------------------------------
module word_swap_ctrl #(
    parameter int LETTER_W = 5,
    parameter int MAX_LEN  = 7,
    parameter int IDX_W    = 3
) (
    input  logic        clk,
    input  logic        rst,
    word_swap_if.slave  bus
);

    // The array spans the full index space so any idx value addresses a real
    // register; slots at or beyond MAX_LEN are never written and stay zero.
    localparam int DEPTH = 2 ** IDX_W;
    localparam int LEN_W = IDX_W + 1;

    typedef enum logic [2:0] {
        EMPTY,
        READY,
        WR1,
        WR2,
        CHECK,
        SOLVED
    } state_t;

    state_t                 state;
    logic [LETTER_W-1:0]    bufMem [DEPTH];
    logic [LETTER_W-1:0]    tgtMem [MAX_LEN];
    logic [LEN_W-1:0]       lenReg;
    logic [IDX_W-1:0]       idxA;
    logic [IDX_W-1:0]       idxB;
    logic [LETTER_W-1:0]    tmpA;
    logic [LETTER_W-1:0]    tmpB;
    logic                   busyR;
    logic                   doneR;
    logic                   errR;
    logic                   correctR;
    logic [6:0]             swapCnt;
    // CHECK entered from a load: evaluate only, no pulse and no count
    logic                   loadChk;
`ifdef SWAP_UNDO_EN
    logic                   lastValid;
    logic                   undoRun;
`endif

    logic [LEN_W-1:0]               newLen;
    logic                           idxBad;
    logic                           matchNow;
    logic [MAX_LEN*LETTER_W-1:0]    wordOut;

    // len_sel 0..3 maps to 4..7 letters
    assign newLen = LEN_W'(bus.len_sel) + LEN_W'(4);

    assign idxBad = ({1'b0, bus.idx1} >= lenReg) || ({1'b0, bus.idx2} >= lenReg);

    // Slots beyond the active length are zero in both arrays after a load,
    // but the compare is still restricted to the active length.
    always_comb begin
        matchNow = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(lenReg)) && (bufMem[i] != tgtMem[i])) begin
                matchNow = 1'b0;
            end
        end
    end

    always_comb begin
        wordOut = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            wordOut[i*LETTER_W +: LETTER_W] = bufMem[i];
        end
    end

    assign bus.word_out   = wordOut;
    assign bus.busy       = busyR;
    assign bus.done_pls   = doneR;
    assign bus.err_pls    = errR;
    assign bus.is_correct = correctR;
    assign bus.swap_cnt   = swapCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            for (int i = 0; i < DEPTH; i++) begin
                bufMem[i] <= '0;
            end
            for (int i = 0; i < MAX_LEN; i++) begin
                tgtMem[i] <= '0;
            end
            lenReg   <= '0;
            idxA     <= '0;
            idxB     <= '0;
            tmpA     <= '0;
            tmpB     <= '0;
            busyR    <= 1'b0;
            doneR    <= 1'b0;
            errR     <= 1'b0;
            correctR <= 1'b0;
            swapCnt  <= '0;
            loadChk  <= 1'b0;
`ifdef SWAP_UNDO_EN
            lastValid <= 1'b0;
            undoRun   <= 1'b0;
`endif
        end else begin
            // Pulses last exactly one cycle unless re-asserted below
            doneR <= 1'b0;
            errR  <= 1'b0;

            if (bus.clear_pls) begin
                for (int i = 0; i < DEPTH; i++) begin
                    bufMem[i] <= '0;
                end
                busyR    <= 1'b0;
                correctR <= 1'b0;
                swapCnt  <= '0;
                loadChk  <= 1'b0;
`ifdef SWAP_UNDO_EN
                lastValid <= 1'b0;
                undoRun   <= 1'b0;
`endif
                state    <= EMPTY;
            end else if (bus.load_pls) begin
                lenReg <= newLen;
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (i < int'(newLen)) begin
                        bufMem[i] <= bus.word_in[i*LETTER_W +: LETTER_W];
                        tgtMem[i] <= bus.target_in[i*LETTER_W +: LETTER_W];
                    end else begin
                        bufMem[i] <= '0;
                        tgtMem[i] <= '0;
                    end
                end
                busyR    <= 1'b0;
                correctR <= 1'b0;
                swapCnt  <= '0;
                loadChk  <= 1'b1;
`ifdef SWAP_UNDO_EN
                lastValid <= 1'b0;
                undoRun   <= 1'b0;
`endif
                state    <= CHECK;
            end else begin
                case (state)
                    READY: begin
                        if (bus.swap_req) begin
                            if (idxBad) begin
                                errR <= 1'b1;
                            end else begin
                                idxA    <= bus.idx1;
                                idxB    <= bus.idx2;
                                tmpA    <= bufMem[bus.idx1];
                                tmpB    <= bufMem[bus.idx2];
                                busyR   <= 1'b1;
                                loadChk <= 1'b0;
`ifdef SWAP_UNDO_EN
                                undoRun <= 1'b0;
`endif
                                state   <= WR1;
                            end
                        end
`ifdef SWAP_UNDO_EN
                        // Re-swapping the stored pair restores the buffer
                        else if (bus.undo_pls && lastValid) begin
                            tmpA    <= bufMem[idxA];
                            tmpB    <= bufMem[idxB];
                            busyR   <= 1'b1;
                            loadChk <= 1'b0;
                            undoRun <= 1'b1;
                            state   <= WR1;
                        end
`endif
                    end

                    WR1: begin
                        bufMem[idxA] <= tmpB;
                        state        <= WR2;
                    end

                    WR2: begin
                        bufMem[idxB] <= tmpA;
                        state        <= CHECK;
                    end

                    CHECK: begin
                        correctR <= matchNow;
                        if (!loadChk) begin
                            busyR <= 1'b0;
                            doneR <= 1'b1;
`ifdef SWAP_UNDO_EN
                            if (undoRun) begin
                                if (swapCnt != 7'd0) begin
                                    swapCnt <= swapCnt - 7'd1;
                                end
                                lastValid <= 1'b0;
                            end else begin
                                if (swapCnt != 7'd127) begin
                                    swapCnt <= swapCnt + 7'd1;
                                end
                                lastValid <= 1'b1;
                            end
                            undoRun <= 1'b0;
`else
                            if (swapCnt != 7'd127) begin
                                swapCnt <= swapCnt + 7'd1;
                            end
`endif
                        end
                        loadChk <= 1'b0;
                        state   <= matchNow ? SOLVED : READY;
                    end

                    // EMPTY and SOLVED hold until clear_pls or load_pls
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_word_swap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_word_swap_ctrl
//   Directed self-checking bench for word_swap_ctrl. Inputs change and outputs
//   are sampled on the falling clock edge. Build with +define+SWAP_UNDO_EN to
//   include the undo scenario.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_word_swap_ctrl;

    typedef logic [34:0] word_t;

    logic clk;
    logic rst;
    int   nCmp;
    int   nFail;

    word_swap_if #(.LETTER_W(5), .MAX_LEN(7), .IDX_W(3)) bus ();

    word_swap_ctrl #(.LETTER_W(5), .MAX_LEN(7), .IDX_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Letter string -> packed word, slot 0 = first character, A = 1
    function automatic word_t mkWord(input string s);
        word_t w;
        w = '0;
        for (int i = 0; i < s.len() && i < 7; i++) begin
            w[i*5 +: 5] = 5'(s[i] - 8'd64);
        end
        return w;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doLoad(input logic [1:0] ls, input string w, input string t);
        bus.len_sel   = ls;
        bus.word_in   = mkWord(w);
        bus.target_in = mkWord(t);
        bus.load_pls  = 1'b1;
        tick();
        bus.load_pls  = 1'b0;
        tick();
    endtask

    // Returns at the sample point after edge N+3
    task automatic doSwap(input logic [2:0] a, input logic [2:0] b);
        bus.idx1     = a;
        bus.idx2     = b;
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        nCmp++;
        if (bus.word_out !== '0) begin
            nFail++; $display("FAIL reset_word: got %h want 0", bus.word_out);
        end
        nCmp++;
        if ({bus.busy, bus.done_pls, bus.err_pls, bus.is_correct, bus.swap_cnt} !== 11'd0) begin
            nFail++; $display("FAIL reset_flags: got %b want 0",
                {bus.busy, bus.done_pls, bus.err_pls, bus.is_correct, bus.swap_cnt});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_solve();
        doLoad(2'd0, "TACOXYZ", "COAT");
        nCmp++;
        if (bus.word_out !== mkWord("TACO")) begin
            nFail++; $display("FAIL solve_load_trunc: got %h want %h", bus.word_out, mkWord("TACO"));
        end
        nCmp++;
        if (bus.is_correct !== 1'b0 || bus.swap_cnt !== 7'd0) begin
            nFail++; $display("FAIL solve_load_state: got corr=%b cnt=%0d want 0/0", bus.is_correct, bus.swap_cnt);
        end
        bus.idx1 = 3'd0; bus.idx2 = 3'd2; bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        nCmp++;
        if (bus.busy !== 1'b1) begin
            nFail++; $display("FAIL solve_busy: got %b want 1", bus.busy);
        end
        tick();
        nCmp++;
        if (bus.word_out !== mkWord("CACO")) begin
            nFail++; $display("FAIL solve_wr1_image: got %h want %h", bus.word_out, mkWord("CACO"));
        end
        tick();
        nCmp++;
        if (bus.done_pls !== 1'b0 || bus.word_out !== mkWord("CATO")) begin
            nFail++; $display("FAIL solve_wr2: got done=%b word=%h want 0/%h", bus.done_pls, bus.word_out, mkWord("CATO"));
        end
        tick();
        nCmp++;
        if (bus.done_pls !== 1'b1 || bus.busy !== 1'b0 || bus.swap_cnt !== 7'd1) begin
            nFail++; $display("FAIL solve_done1: got done=%b busy=%b cnt=%0d want 1/0/1", bus.done_pls, bus.busy, bus.swap_cnt);
        end
        doSwap(3'd1, 3'd3);
        nCmp++;
        if (bus.word_out !== mkWord("COTA") || bus.swap_cnt !== 7'd2) begin
            nFail++; $display("FAIL solve_swap2: got %h cnt=%0d want %h cnt=2", bus.word_out, bus.swap_cnt, mkWord("COTA"));
        end
        doSwap(3'd2, 3'd3);
        nCmp++;
        if (bus.word_out !== mkWord("COAT") || bus.is_correct !== 1'b1 || bus.swap_cnt !== 7'd3) begin
            nFail++; $display("FAIL solve_swap3: got %h corr=%b cnt=%0d want %h/1/3", bus.word_out, bus.is_correct, bus.swap_cnt, mkWord("COAT"));
        end
        // SOLVED ignores further requests
        doSwap(3'd0, 3'd1);
        nCmp++;
        if (bus.word_out !== mkWord("COAT") || bus.swap_cnt !== 7'd3 || bus.done_pls !== 1'b0 || bus.is_correct !== 1'b1) begin
            nFail++; $display("FAIL solve_hold: got %h cnt=%0d done=%b corr=%b want %h/3/0/1", bus.word_out, bus.swap_cnt, bus.done_pls, bus.is_correct, mkWord("COAT"));
        end
    endtask

    task automatic test_bad_index();
        doLoad(2'd1, "HELLO", "HOLLE");
        bus.idx1 = 3'd5; bus.idx2 = 3'd0; bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        nCmp++;
        if (bus.err_pls !== 1'b1 || bus.busy !== 1'b0) begin
            nFail++; $display("FAIL bad_err: got err=%b busy=%b want 1/0", bus.err_pls, bus.busy);
        end
        tick();
        nCmp++;
        if (bus.err_pls !== 1'b0) begin
            nFail++; $display("FAIL bad_err_pulse: got %b want 0", bus.err_pls);
        end
        nCmp++;
        if (bus.word_out !== mkWord("HELLO") || bus.swap_cnt !== 7'd0) begin
            nFail++; $display("FAIL bad_unchanged: got %h cnt=%0d want %h cnt=0", bus.word_out, bus.swap_cnt, mkWord("HELLO"));
        end
        bus.idx1 = 3'd4; bus.idx2 = 3'd7; bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        nCmp++;
        if (bus.err_pls !== 1'b1) begin
            nFail++; $display("FAIL bad_idx2: got %b want 1", bus.err_pls);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        bus.idx1 = 3'd0; bus.idx2 = 3'd1; bus.swap_req = 1'b1;
        tick();
        tick();
        bus.swap_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done_pls === 1'b1) dones++;
            tick();
        end
        nCmp++;
        if (dones !== 1) begin
            nFail++; $display("FAIL b2b_done_count: got %0d want 1", dones);
        end
        nCmp++;
        if (bus.word_out !== mkWord("EHLLO") || bus.swap_cnt !== 7'd1) begin
            nFail++; $display("FAIL b2b_result: got %h cnt=%0d want %h cnt=1", bus.word_out, bus.swap_cnt, mkWord("EHLLO"));
        end
    endtask

    task automatic test_load_abort();
        int dones;
        dones = 0;
        bus.idx1 = 3'd2; bus.idx2 = 3'd3; bus.swap_req = 1'b1;
        tick();
        bus.swap_req  = 1'b0;
        bus.len_sel   = 2'd0;
        bus.word_in   = mkWord("CODE");
        bus.target_in = mkWord("CODE");
        bus.load_pls  = 1'b1;
        tick();
        bus.load_pls  = 1'b0;
        nCmp++;
        if (bus.busy !== 1'b0) begin
            nFail++; $display("FAIL abort_busy: got %b want 0", bus.busy);
        end
        for (int i = 0; i < 5; i++) begin
            if (bus.done_pls === 1'b1) dones++;
            tick();
        end
        nCmp++;
        if (dones !== 0) begin
            nFail++; $display("FAIL abort_no_done: got %0d want 0", dones);
        end
        nCmp++;
        if (bus.word_out !== mkWord("CODE") || bus.swap_cnt !== 7'd0 || bus.is_correct !== 1'b1) begin
            nFail++; $display("FAIL abort_state: got %h cnt=%0d corr=%b want %h/0/1", bus.word_out, bus.swap_cnt, bus.is_correct, mkWord("CODE"));
        end
    endtask

    task automatic test_saturation();
        doLoad(2'd0, "ABCD", "DCBA");
        for (int i = 0; i < 129; i++) begin
            doSwap(3'd3, 3'd3);
            if (i == 0) begin
                nCmp++;
                if (bus.done_pls !== 1'b1 || bus.swap_cnt !== 7'd1 || bus.word_out !== mkWord("ABCD")) begin
                    nFail++; $display("FAIL same_idx: got done=%b cnt=%0d word=%h want 1/1/%h", bus.done_pls, bus.swap_cnt, bus.word_out, mkWord("ABCD"));
                end
            end
        end
        nCmp++;
        if (bus.swap_cnt !== 7'd127 || bus.is_correct !== 1'b0) begin
            nFail++; $display("FAIL sat_count: got cnt=%0d corr=%b want 127/0", bus.swap_cnt, bus.is_correct);
        end
    endtask

    task automatic test_clear();
        bus.clear_pls = 1'b1;
        tick();
        bus.clear_pls = 1'b0;
        nCmp++;
        if (bus.word_out !== '0 || bus.swap_cnt !== 7'd0 || bus.is_correct !== 1'b0 || bus.busy !== 1'b0) begin
            nFail++; $display("FAIL clear_state: got %h cnt=%0d corr=%b busy=%b want 0", bus.word_out, bus.swap_cnt, bus.is_correct, bus.busy);
        end
        doSwap(3'd0, 3'd1);
        nCmp++;
        if (bus.done_pls !== 1'b0 || bus.swap_cnt !== 7'd0 || bus.err_pls !== 1'b0) begin
            nFail++; $display("FAIL clear_ignore: got done=%b cnt=%0d err=%b want 0/0/0", bus.done_pls, bus.swap_cnt, bus.err_pls);
        end
    endtask

`ifdef SWAP_UNDO_EN
    task automatic test_undo();
        doLoad(2'd0, "TACO", "COAT");
        doSwap(3'd1, 3'd2);
        nCmp++;
        if (bus.word_out !== mkWord("TCAO") || bus.swap_cnt !== 7'd1) begin
            nFail++; $display("FAIL undo_pre: got %h cnt=%0d want %h cnt=1", bus.word_out, bus.swap_cnt, mkWord("TCAO"));
        end
        bus.undo_pls = 1'b1;
        tick();
        bus.undo_pls = 1'b0;
        tick(); tick(); tick();
        nCmp++;
        if (bus.done_pls !== 1'b1 || bus.word_out !== mkWord("TACO") || bus.swap_cnt !== 7'd0) begin
            nFail++; $display("FAIL undo_restore: got done=%b %h cnt=%0d want 1/%h/0", bus.done_pls, bus.word_out, bus.swap_cnt, mkWord("TACO"));
        end
        bus.undo_pls = 1'b1;
        tick();
        bus.undo_pls = 1'b0;
        nCmp++;
        if (bus.busy !== 1'b0) begin
            nFail++; $display("FAIL undo_second_busy: got %b want 0", bus.busy);
        end
        tick(); tick(); tick();
        nCmp++;
        if (bus.done_pls !== 1'b0 || bus.word_out !== mkWord("TACO") || bus.swap_cnt !== 7'd0) begin
            nFail++; $display("FAIL undo_second: got done=%b %h cnt=%0d want 0/%h/0", bus.done_pls, bus.word_out, bus.swap_cnt, mkWord("TACO"));
        end
    endtask
`endif

    task automatic test_reset_midswap();
        doLoad(2'd0, "TACO", "COAT");
        bus.idx1 = 3'd0; bus.idx2 = 3'd2; bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        tick();
        // now in WR2
        rst = 1'b1;
        #1;
        nCmp++;
        if (bus.word_out !== '0 || {bus.busy, bus.done_pls, bus.err_pls, bus.is_correct, bus.swap_cnt} !== 11'd0) begin
            nFail++; $display("FAIL midswap_reset: got %h flags=%b want 0", bus.word_out,
                {bus.busy, bus.done_pls, bus.err_pls, bus.is_correct, bus.swap_cnt});
        end
        tick();
        rst = 1'b0;
        tick();
        doSwap(3'd0, 3'd1);
        nCmp++;
        if (bus.word_out !== '0 || bus.done_pls !== 1'b0 || bus.swap_cnt !== 7'd0) begin
            nFail++; $display("FAIL midswap_empty: got %h done=%b cnt=%0d want 0", bus.word_out, bus.done_pls, bus.swap_cnt);
        end
    endtask

    initial begin
        nCmp          = 0;
        nFail         = 0;
        rst           = 1'b1;
        bus.clear_pls = 1'b0;
        bus.load_pls  = 1'b0;
        bus.len_sel   = 2'd0;
        bus.word_in   = '0;
        bus.target_in = '0;
        bus.swap_req  = 1'b0;
        bus.idx1      = '0;
        bus.idx2      = '0;
`ifdef SWAP_UNDO_EN
        bus.undo_pls  = 1'b0;
`endif
        test_reset();
        test_solve();
        test_bad_index();
        test_back_to_back();
        test_load_abort();
        test_saturation();
        test_clear();
`ifdef SWAP_UNDO_EN
        test_undo();
`endif
        test_reset_midswap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
